// File: rtl/ex_seg_reg.sv
// ---------------------------------------------------------------------------
// ex_seg_reg
//   ID->EX pipeline segment register. Captures the decoded control word,
//   operands and register addresses at the end of ID and presents them to EX
//   one cycle later. Supports stall (hold), flush (bubble insertion) and a
//   valid tag per slot. Also keeps a saturating count of the bubbles that
//   enter EX.
//
// Parameters
//   DATA_W   width of PC, immediate and register operands
//   RADDR_W  register-file address width
//   CNT_W    width of the bubble counter
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   en                        1 = advance slot, 0 = hold (stall)
//   clear                     1 = load a bubble (flush)
//   valid_d, ctrl_d           ID valid tag and packed 22-bit decode word
//   pc_d, imm_d               ID PC and extended immediate
//   rs1v_d, rs2v_d            ID register operand values
//   rd_d, rs1_d, rs2_d        ID destination / source register addresses
//   valid_e, ctrl_e, ...      registered copies presented to EX
//   bubble_cnt                bubbles entered into EX since reset, saturating
//
// ctrl map: [21]Jalr [20:18]RegWrite [17]MemToReg [16:13]MemWrite
//   [12]LoadNpc [11:10]RegRead [9:7]BranchType [6:3]AluContrl [2]AluSrc1
//   [1:0]AluSrc2. The all-zero word is the NOP, so a bubble is all zeros.
// ---------------------------------------------------------------------------
module ex_seg_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic               valid_d,
  input  logic [21:0]        ctrl_d,
  input  logic [DATA_W-1:0]  pc_d,
  input  logic [DATA_W-1:0]  imm_d,
  input  logic [DATA_W-1:0]  rs1v_d,
  input  logic [DATA_W-1:0]  rs2v_d,
  input  logic [RADDR_W-1:0] rd_d,
  input  logic [RADDR_W-1:0] rs1_d,
  input  logic [RADDR_W-1:0] rs2_d,
  output logic               valid_e,
  output logic [21:0]        ctrl_e,
  output logic [DATA_W-1:0]  pc_e,
  output logic [DATA_W-1:0]  imm_e,
  output logic [DATA_W-1:0]  rs1v_e,
  output logic [DATA_W-1:0]  rs2v_e,
  output logic [RADDR_W-1:0] rd_e,
  output logic [RADDR_W-1:0] rs1_e,
  output logic [RADDR_W-1:0] rs2_e,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic               valid;
    logic [21:0]        ctrl;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  rs1v;
    logic [DATA_W-1:0]  rs2v;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
  } slot_t;

  slot_t              slot_q, slot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bubble;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next-slot selection: clear beats stall, so a flushed stalled slot still
  // turns into a bubble. Bubbles zero the addresses too, keeping forwarding
  // logic in EX inert without it having to look at valid_e.
  always_comb begin
    slot_d = slot_q;
    bubble = 1'b0;
    if (clear) begin
      slot_d = '0;
      bubble = 1'b1;
    end else if (en) begin
      if (valid_d) begin
        slot_d = '{valid: 1'b1, ctrl: ctrl_d, pc: pc_d, imm: imm_d,
                   rs1v: rs1v_d, rs2v: rs2v_d, rd: rd_d, rs1: rs1_d,
                   rs2: rs2_d};
      end else begin
        slot_d = '0;
        bubble = 1'b1;
      end
    end
    cnt_d = bubble ? sat_inc(cnt_q) : cnt_q;
  end

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_e    = slot_q.valid;
  assign ctrl_e     = slot_q.ctrl;
  assign pc_e       = slot_q.pc;
  assign imm_e      = slot_q.imm;
  assign rs1v_e     = slot_q.rs1v;
  assign rs2v_e     = slot_q.rs2v;
  assign rd_e       = slot_q.rd;
  assign rs1_e      = slot_q.rs1;
  assign rs2_e      = slot_q.rs2;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ex_seg_reg.sv
module tb_ex_seg_reg;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, clear, valid_d;
  logic [21:0]   ctrl_d;
  logic [DW-1:0] pc_d, imm_d, rs1v_d, rs2v_d;
  logic [AW-1:0] rd_d, rs1_d, rs2_d;

  logic          valid_e, valid_e4;
  logic [21:0]   ctrl_e, ctrl_e4;
  logic [DW-1:0] pc_e, imm_e, rs1v_e, rs2v_e, pc_e4, imm_e4, rs1v_e4, rs2v_e4;
  logic [AW-1:0] rd_e, rs1_e, rs2_e, rd_e4, rs1_e4, rs2_e4;
  logic [15:0]   bubble_cnt;
  logic [3:0]    bubble_cnt4;

  ex_seg_reg #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .pc_d(pc_d), .imm_d(imm_d), .rs1v_d(rs1v_d),
    .rs2v_d(rs2v_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .pc_e(pc_e), .imm_e(imm_e),
    .rs1v_e(rs1v_e), .rs2v_e(rs2v_e), .rd_e(rd_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .bubble_cnt(bubble_cnt));

  // Narrow-counter instance sharing the same stimulus, for saturation.
  ex_seg_reg #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .pc_d(pc_d), .imm_d(imm_d), .rs1v_d(rs1v_d),
    .rs2v_d(rs2v_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .valid_e(valid_e4), .ctrl_e(ctrl_e4), .pc_e(pc_e4), .imm_e(imm_e4),
    .rs1v_e(rs1v_e4), .rs2v_e(rs2v_e4), .rd_e(rd_e4), .rs1_e(rs1_e4),
    .rs2_e(rs2_e4), .bubble_cnt(bubble_cnt4));

  typedef struct {
    logic          v;
    logic [21:0]   c;
    logic [DW-1:0] pc, im, a, b;
    logic [AW-1:0] rd, r1, r2;
    int            bubbles;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   bub_total;
  int   checks = 0;
  int   errors = 0;

  localparam int SW = 1 + 22 + 4*DW + 3*AW;

  function automatic logic [SW-1:0] pack(exp_t e);
    return {e.v, e.c, e.pc, e.im, e.a, e.b, e.rd, e.r1, e.r2};
  endfunction

  task automatic chk(input string name, input logic [SW-1:0] act,
                     input logic [SW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: outcome of one edge, from the stated priority rules.
  task automatic step(input logic r, input logic cl, input logic e,
                      input logic vd, input logic [21:0] c,
                      input logic [DW-1:0] p, input logic [DW-1:0] im,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [AW-1:0] rd, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2);
    @(negedge clk);
    rst = r; clear = cl; en = e; valid_d = vd; ctrl_d = c; pc_d = p;
    imm_d = im; rs1v_d = a; rs2v_d = b; rd_d = rd; rs1_d = r1; rs2_d = r2;
    if (r) begin
      m = '{v: 1'b0, c: '0, pc: '0, im: '0, a: '0, b: '0, rd: '0, r1: '0,
            r2: '0, bubbles: 0};
      bub_total = 0;
    end else if (cl || (e && !vd)) begin
      bub_total++;
      m = '{v: 1'b0, c: '0, pc: '0, im: '0, a: '0, b: '0, rd: '0, r1: '0,
            r2: '0, bubbles: 0};
    end else if (e) begin
      m = '{v: 1'b1, c: c, pc: p, im: im, a: a, b: b, rd: rd, r1: r1,
            r2: r2, bubbles: 0};
    end
    m.bubbles = bub_total;
    q.push_back(m);
  endtask

  task automatic rnd_step(input logic r, input logic cl, input logic e,
                          input logic vd);
    step(r, cl, e, vd, 22'($urandom), $urandom, $urandom, $urandom, $urandom,
         5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  // Monitor: the slot presents a result after every edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("slot", {valid_e, ctrl_e, pc_e, imm_e, rs1v_e, rs2v_e, rd_e,
                     rs1_e, rs2_e}, pack(x));
        chk("slot_w4", {valid_e4, ctrl_e4, pc_e4, imm_e4, rs1v_e4, rs2v_e4,
                        rd_e4, rs1_e4, rs2_e4}, pack(x));
        chk("bubble_cnt", SW'(bubble_cnt),
            SW'((x.bubbles > 65535) ? 65535 : x.bubbles));
        chk("bubble_cnt_w4", SW'(bubble_cnt4),
            SW'((x.bubbles > 15) ? 15 : x.bubbles));
      end
    end
  end

  initial begin
    int k;
    rst = 1'b0; en = 1'b0; clear = 1'b0; valid_d = 1'b0; ctrl_d = '0;
    pc_d = '0; imm_d = '0; rs1v_d = '0; rs2v_d = '0; rd_d = '0; rs1_d = '0;
    rs2_d = '0;
    m = '{v: 1'b0, c: '0, pc: '0, im: '0, a: '0, b: '0, rd: '0, r1: '0,
          r2: '0, bubbles: 0};
    bub_total = 0;

    // reset with every input driven high
    step(1, 1, 1, 1, '1, '1, '1, '1, '1, '1, '1, '1);
    // valid load, then three stalled cycles with changing inputs
    step(0, 0, 1, 1, 22'h0A5A5A, 32'h100, 32'h1234, 32'hDEAD, 32'hBEEF,
         5'd5, 5'd7, 5'd9);
    repeat (3) rnd_step(0, 0, 0, 1);
    // flush while stalled
    step(0, 1, 0, 1, 22'h3FFFFF, 32'h200, 32'h1, 32'h2, 32'h3, 5'd6, 5'd1,
         5'd2);
    // valid load then a load with valid_d=0 and a nonzero ctrl word
    rnd_step(0, 0, 1, 1);
    step(0, 0, 1, 0, 22'h3FFFFF, 32'h300, 32'h4, 32'h5, 32'h6, 5'd31, 5'd3,
         5'd4);
    // 20 consecutive flushes: narrow counter must pin at 15
    repeat (20) rnd_step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
    // reset arriving on a stalled valid slot, and alongside a flush
    rnd_step(0, 0, 1, 1);
    rnd_step(0, 0, 0, 1);
    rnd_step(1, 0, 0, 1);
    rnd_step(0, 0, 1, 1);
    rnd_step(1, 1, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd_step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
    end

    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
